// File: rtl/aes_pkg.sv
// AES-128 shared types, constants and byte/word helpers.
// Used by both the forward and inverse key schedules.
package aes_pkg;
    localparam int AES_NB = 4;
    localparam int AES_NK = 4;
    localparam int AES_NR = 10;

    typedef logic [127:0] rkey_t;
    typedef logic [31:0]  word_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} iks_state_t;

    localparam byte_t RCON_LAST = 8'h36;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX[b];
    endfunction

    // Inverse of xtime in GF(2^8): walks Rcon backwards (36 -> 1b -> 80 ...)
    function automatic byte_t inv_xtime(input byte_t x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups, purely combinational.
module sub_word
    import aes_pkg::*;
(
    input  word_t word,
    output word_t sub
);
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign sub[8*i +: 8] = sbox(word[8*i +: 8]);
    end
endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: emits round keys NR down to 0
// over a valid/ready stream, one key per accepted transfer.
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int          NR        = AES_NR,
    parameter logic [7:0]  RCON_LAST = aes_pkg::RCON_LAST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_last,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);
    iks_state_t state_q, state_d;
    rkey_t      key_q;
    logic [3:0] round_q;
    byte_t      rcon_q;
    logic       load, step;

    word_t k0, k1, k2, k3;
    word_t p0, p1, p2, p3;
    word_t sw;

    assign {k0, k1, k2, k3} = key_q;
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;

    sub_word u_sub_word (
        .word (rot_word(p3)),
        .sub  (sw)
    );

    assign p0 = k0 ^ sw ^ {rcon_q, 24'h0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= '0;
        end else if (load) begin
            key_q   <= key_last;
            round_q <= 4'(NR);
            rcon_q  <= RCON_LAST;
        end else if (step) begin
            key_q   <= {p0, p1, p2, p3};
            round_q <= round_q - 4'd1;
            rcon_q  <= inv_xtime(rcon_q);
        end
    end

    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign done     = (state_q == DONE);
endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule with a forward-expansion reference
// model and an expected-key queue.
module tb_inv_key_schedule;
    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        logic [7:0]   rcon;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_last;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   tb_sbox  [256];
    logic [7:0]   rcon_tab [11];
    logic [127:0] exp_rk   [11];
    logic [127:0] got_rk   [11];
    exp_t         sb_q     [$];

    always #5 clk = ~clk;

    inv_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_last (key_last),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Reference S-box from the GF(2^8) inverse plus affine map
    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                       ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        rcon_tab[0] = 8'h00;
        rcon_tab[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rcon_tab[i] = gmul(rcon_tab[i-1], 8'h02);
    endtask

    function automatic logic [31:0] tb_subw(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = tb_subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // mode 0: ready=1, 1: random stalls, 2: start at round 5, 3: reset at round 4
    task automatic run_seq(input int mode);
        exp_t         e;
        int           dones;
        int           tail;
        int           stall_left;
        bit           stalled;
        bit           injected;
        bit           fin;
        bit           done_next;
        bit           rdy;
        logic [127:0] hold_k;
        logic [3:0]   hold_r;
        dones = 0; tail = -1; stall_left = 0;
        stalled = 0; injected = 0; fin = 0; done_next = 0;
        hold_k = '0; hold_r = '0;
        sb_q.delete();
        for (int r = 0; r <= 10; r++) got_rk[r] = '0;
        for (int r = 10; r >= 0; r--) sb_q.push_back('{4'(r), exp_rk[r], rcon_tab[r]});
        key_last = exp_rk[10];
        start    = 1'b1;
        rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("first_valid", {126'b0, rk_valid, busy}, 128'h3);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (done) dones++;
            if (done_next) chk("done_pulse", 128'(done), 128'h1);
            done_next = 0;
            if (stalled) begin
                chk("stall_key", rk_out, hold_k);
                chk("stall_round", 128'(rk_round), 128'(hold_r));
            end
            stalled = 0;
            if (tail == 0) fin = 1;
            else if (tail > 0) tail--;
            if (mode == 3 && rk_valid && rk_round == 4'd4) begin
                rk_ready = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("rst_key", rk_out, '0);
                chk("rst_ctl", {113'b0, rk_round, rk_valid, busy, done, dut.rcon_q}, '0);
                @(negedge clk);
                rst = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (done) dones++;
                end
                sb_q.delete();
                fin = 1;
            end else begin
                if (mode == 2 && rk_valid && rk_round == 4'd5 && !injected) begin
                    start    = 1'b1;
                    key_last = ~exp_rk[10];
                    injected = 1;
                end else begin
                    start = 1'b0;
                end
                if (rk_valid) begin
                    if (mode == 1) begin
                        if (stall_left > 0) begin
                            rdy = 0;
                            stall_left--;
                        end else if ($urandom_range(0, 2) == 0) begin
                            rdy = 0;
                            stall_left = int'($urandom_range(0, 3));
                        end else begin
                            rdy = 1;
                        end
                    end else begin
                        rdy = 1;
                    end
                    rk_ready = rdy;
                    if (rdy) begin
                        chk("sb_nonempty", 128'(sb_q.size() != 0), 128'h1);
                        if (sb_q.size() != 0) begin
                            e = sb_q.pop_front();
                            chk("round", 128'(rk_round), 128'(e.round));
                            chk("key", rk_out, e.key);
                            if (e.round != 4'd0) chk("rcon", 128'(dut.rcon_q), 128'(e.rcon));
                            got_rk[e.round] = rk_out;
                            if (e.round == 4'd0) begin
                                done_next = 1;
                                tail = 4;
                            end
                        end
                    end else begin
                        stalled = 1;
                        hold_k  = rk_out;
                        hold_r  = rk_round;
                    end
                end else begin
                    rk_ready = 1'($urandom_range(0, 1));
                end
                if (!fin) @(negedge clk);
            end
        end
        start = 1'b0;
        chk("no_timeout", 128'(fin), 128'h1);
        chk("done_count", 128'(dones), (mode == 3) ? 128'h0 : 128'h1);
        if (mode != 3) chk("sb_drained", 128'(sb_q.size()), 128'h0);
    endtask

    initial begin
        logic [127:0] k;
        build_tables();
        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_last = '0;
        #12;
        chk("reset_key", rk_out, '0);
        chk("reset_ctl", {121'b0, rk_round, rk_valid, busy, done}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_seq(0);
        chk("a1_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("a1_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("a1_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a1_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        run_seq(1);
        chk("bp_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        run_seq(2);
        chk("busy_start_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        run_seq(3);
        run_seq(0);
        chk("post_rst_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("post_rst_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        for (int i = 0; i < 20; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            run_seq(i % 2);
            chk("roundtrip_r0", got_rk[0], k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
